// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter:
// widths, EX command encodings and status-register bit positions.
package alu_share_arbiter_pkg;

   localparam int WORD_WIDTH = 32;
   localparam int CMD_WIDTH  = 4;

   localparam logic [CMD_WIDTH-1:0] EX_ADD = 4'h1;
   localparam logic [CMD_WIDTH-1:0] EX_ADC = 4'h2;
   localparam logic [CMD_WIDTH-1:0] EX_SUB = 4'h3;
   localparam logic [CMD_WIDTH-1:0] EX_SBC = 4'h4;
   localparam logic [CMD_WIDTH-1:0] EX_AND = 4'h5;
   localparam logic [CMD_WIDTH-1:0] EX_OR  = 4'h6;
   localparam logic [CMD_WIDTH-1:0] EX_XOR = 4'h7;
   localparam logic [CMD_WIDTH-1:0] EX_MOV = 4'h8;

   localparam int SR_Z = 3;
   localparam int SR_C = 2;
   localparam int SR_N = 1;
   localparam int SR_V = 0;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Single-cycle combinational ALU producing a result and {Z,C,N,V}.
// Subtraction is a + ~b + 1, so C=1 means no borrow.
module alu_share_arbiter_alu
   import alu_share_arbiter_pkg::*;
#(
   parameter int W = WORD_WIDTH
) (
   input  logic [W-1:0]         i_val1,
   input  logic [W-1:0]         i_val2,
   input  logic                 i_cin,
   input  logic [CMD_WIDTH-1:0] i_cmd,
   output logic [W-1:0]         o_alu_out,
   output logic [3:0]           o_sr
);

   logic [W-1:0] w_b;
   logic         w_ci;
   logic         w_arith;
   logic [W:0]   w_sum;

   always_comb begin
      w_b     = i_val2;
      w_ci    = 1'b0;
      w_arith = 1'b0;
      case (i_cmd)
         EX_ADD: w_arith = 1'b1;
         EX_ADC: begin
            w_arith = 1'b1;
            w_ci    = i_cin;
         end
         EX_SUB: begin
            w_arith = 1'b1;
            w_b     = ~i_val2;
            w_ci    = 1'b1;
         end
         EX_SBC: begin
            w_arith = 1'b1;
            w_b     = ~i_val2;
            w_ci    = i_cin;
         end
         default: ;
      endcase
   end

   assign w_sum = {1'b0, i_val1} + {1'b0, w_b} + {{W{1'b0}}, w_ci};

   always_comb begin
      o_alu_out = '0;
      case (i_cmd)
         EX_ADD, EX_ADC,
         EX_SUB, EX_SBC: o_alu_out = w_sum[W-1:0];
         EX_AND:         o_alu_out = i_val1 & i_val2;
         EX_OR:          o_alu_out = i_val1 | i_val2;
         EX_XOR:         o_alu_out = i_val1 ^ i_val2;
         EX_MOV:         o_alu_out = i_val2;
         default:        o_alu_out = '0;
      endcase
   end

   always_comb begin
      o_sr       = '0;
      o_sr[SR_Z] = (o_alu_out == '0);
      o_sr[SR_C] = w_arith & w_sum[W];
      o_sr[SR_N] = o_alu_out[W-1];
      o_sr[SR_V] = w_arith & (i_val1[W-1] == w_b[W-1])
                 & (o_alu_out[W-1] != i_val1[W-1]);
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between the EX stage (port 0) and an
// auxiliary unit (port 1), with a registered result slot and the SR.
module alu_share_arbiter #(
   parameter int WORD_WIDTH = alu_share_arbiter_pkg::WORD_WIDTH,
   parameter int CMD_WIDTH  = alu_share_arbiter_pkg::CMD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [WORD_WIDTH-1:0] req0_val1,
   input  logic [WORD_WIDTH-1:0] req0_val2,
   input  logic [CMD_WIDTH-1:0]  req0_cmd,
   input  logic                  req0_s,
   input  logic [WORD_WIDTH-1:0] req1_val1,
   input  logic [WORD_WIDTH-1:0] req1_val2,
   input  logic [CMD_WIDTH-1:0]  req1_cmd,
   input  logic                  req1_s,
   output logic [1:0]            resp_valid,
   input  logic [1:0]            resp_ready,
   output logic [WORD_WIDTH-1:0] resp_data,
   output logic [3:0]            resp_sr,
   output logic [3:0]            sr
);

   import alu_share_arbiter_pkg::*;

   out_state_t            r_state;
   out_state_t            w_state_nxt;
   logic                  r_owner;
   logic                  r_rr_last;
   logic [WORD_WIDTH-1:0] r_data;
   logic [3:0]            r_rsr;
   logic [3:0]            r_sr;

   logic                  w_can_issue;
   logic [1:0]            w_grant;
   logic                  w_accept;
   logic                  w_sel;
   logic [WORD_WIDTH-1:0] w_val1;
   logic [WORD_WIDTH-1:0] w_val2;
   logic [CMD_WIDTH-1:0]  w_cmd;
   logic                  w_s;
   logic [WORD_WIDTH-1:0] w_alu_out;
   logic [3:0]            w_alu_sr;

   // On a tie the port that did not win last time is granted.
   always_comb begin
      w_grant = 2'b00;
      case (req_valid)
         2'b01:   w_grant = 2'b01;
         2'b10:   w_grant = 2'b10;
         2'b11:   w_grant = r_rr_last ? 2'b01 : 2'b10;
         default: w_grant = 2'b00;
      endcase
   end

   assign w_can_issue = (r_state == ST_EMPTY) | resp_ready[r_owner];
   assign req_ready   = w_can_issue ? w_grant : 2'b00;
   assign w_accept    = |(req_valid & req_ready);
   assign w_sel       = req_ready[1];

   assign w_val1 = w_sel ? req1_val1 : req0_val1;
   assign w_val2 = w_sel ? req1_val2 : req0_val2;
   assign w_cmd  = w_sel ? req1_cmd  : req0_cmd;
   assign w_s    = w_sel ? req1_s    : req0_s;

   alu_share_arbiter_alu #(
      .W (WORD_WIDTH)
   ) u_alu (
      .i_val1    (w_val1),
      .i_val2    (w_val2),
      .i_cin     (r_sr[SR_C]),
      .i_cmd     (w_cmd),
      .o_alu_out (w_alu_out),
      .o_sr      (w_alu_sr)
   );

   always_comb begin
      w_state_nxt = r_state;
      resp_valid  = 2'b00;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) w_state_nxt = ST_FULL;
         end
         ST_FULL: begin
            resp_valid = r_owner ? 2'b10 : 2'b01;
            if (resp_ready[r_owner] && !w_accept)
               w_state_nxt = ST_EMPTY;
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_EMPTY;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_owner   <= 1'b0;
         r_rr_last <= 1'b1;
         r_data    <= '0;
         r_rsr     <= '0;
         r_sr      <= '0;
      end else if (w_accept) begin
         r_owner   <= w_sel;
         r_rr_last <= w_sel;
         r_data    <= w_alu_out;
         r_rsr     <= w_alu_sr;
         if (w_s) r_sr <= w_alu_sr;
      end
   end

   assign resp_data = r_data;
   assign resp_sr   = r_rsr;
   assign sr        = r_sr;

endmodule
